// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between pixel-tick source and colour generator (frame_cnt with VGA_FRAME_CNT_EN)
interface vga_timing_gen_if #(
  parameter int HW          = 10,
  parameter int VW          = 10,
  parameter int FRAME_CNT_W = 8
);
  logic          enable;
  logic [HW-1:0] pixel_x;
  logic [VW-1:0] pixel_y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_done;
  logic          frame_done;
`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

  modport master (
    input  enable,
    output pixel_x, pixel_y, hsync, vsync, video_on, line_done, frame_done
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output enable,
    input  pixel_x, pixel_y, hsync, vsync, video_on, line_done, frame_done
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator (VGA_FRAME_CNT_EN adds a frame counter)
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int FRAME_CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          h_last, v_last;
  logic          line_done, frame_done;

  assign h_last     = (h_cnt_q == H_LAST);
  assign v_last     = (v_cnt_q == V_LAST);
  assign line_done  = vga.enable & h_last;
  assign frame_done = line_done & v_last;

  // Sync and blanking decode the next-state counts so the registered outputs line up with pixel_x/pixel_y.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vga.enable) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end
    end
    hsync_d    = ((h_cnt_d >= HS_START) && (h_cnt_d <= HS_END)) ? HS_ON : ~HS_ON;
    vsync_d    = ((v_cnt_d >= VS_START) && (v_cnt_d <= VS_END)) ? VS_ON : ~VS_ON;
    video_on_d = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      hsync_q    <= ~HS_ON;
      vsync_q    <= ~VS_ON;
      video_on_q <= 1'b1;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(frame_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.pixel_x    = h_cnt_q;
  assign vga.pixel_y    = v_cnt_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = video_on_q;
  assign vga.line_done  = line_done;
  assign vga.frame_done = frame_done;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator that supersedes the single-axis pixel counter.
- Contains a horizontal pixel counter and a vertical line counter, chained together.
- Produces hsync, vsync, video_on, the pixel_x/pixel_y coordinates, and line/frame boundary strobes.
- Sits between the pixel-clock enable source and the pixel/colour generator. Timing, porches and sync polarities are all set by parameters.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- VS_POL, 0, vsync active level (0 = active-low, 1 = active-high)
- FRAME_CNT_W, 8, frame counter width (used only with the optional feature)
- Derived localparams:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
  - HW = $clog2(H_TOTAL)
  - VW = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  pixel tick; the counters advance only on clk edges where enable=1
- pixel_x  out  HW  current horizontal count (h_cnt), 0..H_TOTAL-1
- pixel_y  out  VW  current vertical count (v_cnt), 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_on  out  1  high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
- line_done  out  1  single-cycle strobe on the last pixel of each line
- frame_done  out  1  single-cycle strobe on the last pixel of each frame

Behaviour:
- Clocking and reset:
  - One clock, clk. reset is synchronous and active-high.
  - reset has priority over enable.
- Reset values:
  - h_cnt=0, v_cnt=0, video_on=1.
  - hsync=~HS_POL, vsync=~VS_POL (both inactive).
  - line_done=0, frame_done=0.
- h_cnt, on each clk edge with enable=1:
  - If h_cnt==H_TOTAL-1, it wraps to 0. Otherwise it increments.
  - The wrap compare is against the counter register, never against a strobe.
- v_cnt:
  - Advances only on an edge where enable=1 and h_cnt==H_TOTAL-1.
  - Wraps from V_TOTAL-1 to 0, otherwise increments.
- enable=0: every register holds. Strobes are 0.
- pixel_x/pixel_y are driven directly from the counter registers (zero latency).
- hsync, vsync and video_on are registered. Each is computed from the next-state counter values, so it is aligned with pixel_x/pixel_y in the same cycle (no skew).
- hsync is active (=HS_POL) for H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1; inactive otherwise.
- vsync is active (=VS_POL) for V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1, for the full line width.
- Strobes (combinational):
  - line_done = enable & (h_cnt==H_TOTAL-1).
  - frame_done = line_done & (v_cnt==V_TOTAL-1).
- Boundaries:
  - Simultaneous h and v wrap: both counters return to 0 on the same edge.
  - A stalled enable on the last pixel keeps the counters there, and no strobe fires until enable returns.
- Reset mid-frame: on the next edge, all outputs return to their reset values regardless of enable.
- All arithmetic is unsigned. The counters never reach H_TOTAL or V_TOTAL.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt [FRAME_CNT_W-1:0]. It resets to 0.
  - Increments on every edge where frame_done=1, wrapping modulo 2^FRAME_CNT_W.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset with enable=1 held for 2 clocks, then release:
  - While reset is asserted: pixel_x=0, pixel_y=0, video_on=1, hsync=1, vsync=1 (defaults).
  - After release: pixel_x counts 1,2,3 on successive clocks.
- Free run, enable=1, default params:
  - hsync=0 exactly for pixel_x 656..751 (96 clocks).
  - video_on falls at pixel_x=640.
  - line_done pulses once every 800 clocks, at pixel_x=799.
- Full frame, enable=1:
  - vsync=0 for pixel_y 490..491 (1600 clocks).
  - frame_done is a single pulse at (799,524), followed by (0,0).
  - With VGA_FRAME_CNT_EN, frame_cnt goes 0 to 1.
- enable toggled 1,0,0,1 at pixel_x=799:
  - Counters hold at 799 while enable=0, with no strobe.
  - Wrap to 0 happens only on the re-enabled edge.
- reset asserted at (300,200) with enable=1 → on the next edge pixel_x=0, pixel_y=0, and sync outputs are inactive.
- Small params (H 4/1/2/1, V 3/1/1/1), HS_POL=VS_POL=1:
  - H_TOTAL=8: hsync high at pixel_x 5..6.
  - vsync high on line 4.
  - Wrap after line 5.
  - With VGA_FRAME_CNT_EN and FRAME_CNT_W=2: frame_cnt goes 3 to 0 on the fourth frame.
